instr_fetcher: RTL and testbench
================================

Name: instr_fetcher

Overview:
Per-core instruction fetch unit. It reads the program counter produced by the core's PC stage and issues a single read request to the program memory controller. It then captures the returned instruction word for the decoder. It is the consumer of current_pc, i.e. the read side of the PC-to-fetch interface, and is sequenced by the core scheduler's core_state.

Parameters:
PROGRAM_MEM_ADDR_BITS, 8, program memory address width (matches PC width)
PROGRAM_MEM_DATA_BITS, 16, instruction word width

Ports:
clk  input  1  core clock, all state updates on posedge
reset  input  1  asynchronous, active-high; clears all state immediately
enable  input  1  block active (thread block dispatched to this core); low = freeze
core_state  input  3  scheduler state: IDLE=000 FETCH=001 DECODE=010 REQUEST=011 WAIT=100 EXECUTE=101 UPDATE=110 DONE=111
current_pc  input  PROGRAM_MEM_ADDR_BITS  PC to fetch from
mem_read_valid  output  1  read request to program memory controller
mem_read_address  output  PROGRAM_MEM_ADDR_BITS  request address
mem_read_ready  input  1  controller response strobe, data valid this cycle
mem_read_data  input  PROGRAM_MEM_DATA_BITS  returned instruction word
fetcher_state  output  3  IDLE=000 FETCHING=001 FETCHED=010
instruction  output  PROGRAM_MEM_DATA_BITS  captured instruction to decoder

Behaviour:
- All outputs registered. Reset (async assert): fetcher_state=IDLE, mem_read_valid=0, mem_read_address=0, instruction=0.
- enable=0: no state, output or register changes. This holds mid-request as well: mem_read_valid and mem_read_address are frozen, and mem_read_ready is ignored while disabled.
- IDLE: if core_state==FETCH at a posedge, then mem_read_valid<=1, mem_read_address<=current_pc, fetcher_state<=FETCHING. Otherwise hold.
- FETCHING:
  - mem_read_valid and mem_read_address are held stable until the response arrives. There is no abort path, even if core_state leaves FETCH.
  - If mem_read_ready=1 at a posedge: instruction<=mem_read_data, mem_read_valid<=0, fetcher_state<=FETCHED.
  - current_pc changes while FETCHING are ignored.
- FETCHED: instruction is held. If core_state==DECODE, fetcher_state<=IDLE; otherwise remain in FETCHED. instruction stays stable until the next capture.
- mem_read_ready asserted while mem_read_valid=0 (IDLE/FETCHED): ignored; instruction is unchanged.
- Latency:
  - FETCH sampled at edge N gives mem_read_valid=1 after N.
  - ready sampled at edge M>N gives FETCHED and a valid instruction after M.
  - Minimum FETCH-to-FETCHED is 2 edges.
- Exactly one memory transaction per FETCH-to-FETCHED sequence. mem_read_valid never re-asserts until the FSM returns to IDLE and sees FETCH again.
- core_state==FETCH while in FETCHED (scheduler error): stay FETCHED; no new request.
- Reset asserted mid-request: mem_read_valid drops immediately. The controller is required to discard the pending response.
- Widths: mem_read_address is a direct copy of current_pc with no arithmetic and no wrap logic.

Optional Feature:
Macro FETCH_PC_HIT_EN.
- Defined:
  - The block keeps a single-entry tag (last_pc, last_valid). last_valid is cleared by reset and set on every memory capture, with last_pc<=mem_read_address.
  - In IDLE with core_state==FETCH, last_valid=1 and current_pc==last_pc: go directly to FETCHED in one edge. No request is issued (mem_read_valid stays 0) and instruction is unchanged.
  - On a miss, behaviour is identical to the baseline.
- Not defined: every FETCH issues a memory request; no tag registers exist.

Test Plan:
- Reset: assert reset mid-FETCHING at pc=0x05 -> mem_read_valid=0, fetcher_state=000, instruction=0 without waiting for a clock edge.
- Basic fetch: current_pc=0x12, core_state=FETCH, ready 3 cycles later with data 0x3A41 -> mem_read_address=0x12 held stable throughout. fetcher_state=010 and instruction=0x3A41 after the ready edge. After core_state=DECODE, fetcher_state=000.
- Zero-wait: ready high on the first cycle after valid rises, pc=0xFF, data 0xF000 -> FETCHED after 2 edges total; exactly one valid pulse.
- Stall: enable=0 for 4 cycles while FETCHING with ready pulsed high -> no capture. After re-enable and ready, instruction is captured from the data present at that edge.
- Spurious ready: ready=1, data=0xBEEF while IDLE and while FETCHED -> instruction unchanged, fetcher_state unchanged.
- FETCH_PC_HIT_EN: two consecutive fetches at pc=0x20 -> the second reaches FETCHED in 1 edge with mem_read_valid never asserting and instruction equal to the first fetch's data. A fetch at 0x21 issues a request.

Source files
------------

// File: rtl/instr_fetcher.sv
// instr_fetcher: per-core fetch unit; issues one program-memory read per FETCH
// and holds the returned word for the decoder. Optional macro: FETCH_PC_HIT_EN.
//
// Ports:
//   clk, reset (async, active-high), enable (low = full freeze)
//   core_state       : scheduler state (FETCH=001, DECODE=010)
//   current_pc       : address to fetch
//   mem_read_valid   : request strobe, held until mem_read_ready
//   mem_read_address : request address, copy of current_pc at issue
//   mem_read_ready   : response strobe, mem_read_data valid this cycle
//   mem_read_data    : returned instruction word
//   fetcher_state    : IDLE=000 FETCHING=001 FETCHED=010
//   instruction      : last captured instruction
//
// FETCH_PC_HIT_EN: a single-entry tag lets a FETCH of the most recently
// fetched PC skip the memory request and reuse the held instruction.

module instr_fetcher #(
    parameter int PROGRAM_MEM_ADDR_BITS = 8,
    parameter int PROGRAM_MEM_DATA_BITS = 16
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             enable,
    input  logic [2:0]                       core_state,
    input  logic [PROGRAM_MEM_ADDR_BITS-1:0] current_pc,
    output logic                             mem_read_valid,
    output logic [PROGRAM_MEM_ADDR_BITS-1:0] mem_read_address,
    input  logic                             mem_read_ready,
    input  logic [PROGRAM_MEM_DATA_BITS-1:0] mem_read_data,
    output logic [2:0]                       fetcher_state,
    output logic [PROGRAM_MEM_DATA_BITS-1:0] instruction
);

    typedef enum logic [2:0] {
        S_IDLE     = 3'b000,
        S_FETCHING = 3'b001,
        S_FETCHED  = 3'b010
    } fstate_t;

    localparam logic [2:0] CORE_FETCH  = 3'b001;
    localparam logic [2:0] CORE_DECODE = 3'b010;

    fstate_t                          state_q;
    logic                             valid_q;
    logic [PROGRAM_MEM_ADDR_BITS-1:0] addr_q;
    logic [PROGRAM_MEM_DATA_BITS-1:0] instr_q;

`ifdef FETCH_PC_HIT_EN
    logic [PROGRAM_MEM_ADDR_BITS-1:0] last_pc_q;
    logic                             last_valid_q;
    logic                             hit;

    assign hit = last_valid_q && (current_pc == last_pc_q);
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            valid_q <= 1'b0;
            addr_q  <= '0;
            instr_q <= '0;
`ifdef FETCH_PC_HIT_EN
            last_pc_q    <= '0;
            last_valid_q <= 1'b0;
`endif
        end else if (enable) begin
            unique case (state_q)
                S_IDLE: begin
                    if (core_state == CORE_FETCH) begin
`ifdef FETCH_PC_HIT_EN
                        if (hit) begin
                            // Held instruction already belongs to this PC.
                            state_q <= S_FETCHED;
                        end else begin
                            valid_q <= 1'b1;
                            addr_q  <= current_pc;
                            state_q <= S_FETCHING;
                        end
`else
                        valid_q <= 1'b1;
                        addr_q  <= current_pc;
                        state_q <= S_FETCHING;
`endif
                    end
                end
                S_FETCHING: begin
                    // No abort: request stays up until the response lands.
                    if (mem_read_ready) begin
                        instr_q <= mem_read_data;
                        valid_q <= 1'b0;
                        state_q <= S_FETCHED;
`ifdef FETCH_PC_HIT_EN
                        last_pc_q    <= addr_q;
                        last_valid_q <= 1'b1;
`endif
                    end
                end
                S_FETCHED: begin
                    if (core_state == CORE_DECODE) begin
                        state_q <= S_IDLE;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign mem_read_valid   = valid_q;
    assign mem_read_address = addr_q;
    assign fetcher_state    = state_q;
    assign instruction      = instr_q;

endmodule

// File: tb/tb_instr_fetcher.sv
// tb_instr_fetcher: directed scenarios plus a randomized run against a
// transaction-level reference model of the fetch unit.

module tb_instr_fetcher;

    logic        clk;
    logic        reset;
    logic        enable;
    logic [2:0]  core_state;
    logic [7:0]  current_pc;
    logic        mem_read_valid;
    logic [7:0]  mem_read_address;
    logic        mem_read_ready;
    logic [15:0] mem_read_data;
    logic [2:0]  fetcher_state;
    logic [15:0] instruction;

    int total = 0;
    int bad   = 0;

    localparam logic [2:0] C_IDLE   = 3'b000;
    localparam logic [2:0] C_FETCH  = 3'b001;
    localparam logic [2:0] C_DECODE = 3'b010;
    localparam logic [2:0] C_EXEC   = 3'b101;

    instr_fetcher #(
        .PROGRAM_MEM_ADDR_BITS(8),
        .PROGRAM_MEM_DATA_BITS(16)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .enable          (enable),
        .core_state      (core_state),
        .current_pc      (current_pc),
        .mem_read_valid  (mem_read_valid),
        .mem_read_address(mem_read_address),
        .mem_read_ready  (mem_read_ready),
        .mem_read_data   (mem_read_data),
        .fetcher_state   (fetcher_state),
        .instruction     (instruction)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [27:0] obs();
        return {fetcher_state, mem_read_valid, mem_read_address, instruction};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Run one full fetch from IDLE with a given latency; leaves FETCHED.
    task automatic do_fetch(input logic [7:0] pc, input logic [15:0] d,
                            input int wait_cycles);
        current_pc = pc;
        core_state = C_FETCH;
        tick();
        core_state = C_IDLE;
        repeat (wait_cycles) tick();
        mem_read_ready = 1'b1;
        mem_read_data  = d;
        tick();
        mem_read_ready = 1'b0;
    endtask

    task automatic go_idle();
        core_state = C_DECODE;
        tick();
        core_state = C_IDLE;
    endtask

    task automatic test_reset();
        logic [27:0] exp;
        exp = {3'b000, 1'b0, 8'h00, 16'h0000};
        total++;
        if (obs() !== exp) begin
            bad++;
            $display("FAIL reset_init got=%h want=%h", obs(), exp);
        end
        reset = 1'b0;
        do_fetch(8'h07, 16'h1234, 1);
        go_idle();
        current_pc = 8'h05;
        core_state = C_FETCH;
        tick();
        core_state = C_IDLE;
        exp = {3'b001, 1'b1, 8'h05, 16'h1234};
        total++;
        if (obs() !== exp) begin
            bad++;
            $display("FAIL reset_prefetch got=%h want=%h", obs(), exp);
        end
        #2 reset = 1'b1;
        #1;
        exp = {3'b000, 1'b0, 8'h00, 16'h0000};
        total++;
        if (obs() !== exp) begin
            bad++;
            $display("FAIL reset_async got=%h want=%h", obs(), exp);
        end
        tick();
        reset = 1'b0;
    endtask

    task automatic test_basic();
        logic [27:0] exp;
        current_pc = 8'h12;
        core_state = C_FETCH;
        tick();
        core_state = C_IDLE;
        current_pc = 8'h55;
        for (int i = 0; i < 3; i++) begin
            exp = {3'b001, 1'b1, 8'h12, 16'h0000};
            total++;
            if (obs() !== exp) begin
                bad++;
                $display("FAIL basic_hold%0d got=%h want=%h", i, obs(), exp);
            end
            if (i < 2) tick();
        end
        mem_read_ready = 1'b1;
        mem_read_data  = 16'h3A41;
        tick();
        mem_read_ready = 1'b0;
        exp = {3'b010, 1'b0, 8'h12, 16'h3A41};
        total++;
        if (obs() !== exp) begin
            bad++;
            $display("FAIL basic_capture got=%h want=%h", obs(), exp);
        end
        go_idle();
        total++;
        if (fetcher_state !== 3'b000) begin
            bad++;
            $display("FAIL basic_decode got=%h want=0", fetcher_state);
        end
    endtask

    task automatic test_zero_wait();
        logic [27:0] exp;
        int pulses;
        pulses = 0;
        current_pc = 8'hFF;
        core_state = C_FETCH;
        tick();
        if (mem_read_valid === 1'b1) pulses++;
        core_state     = C_FETCH;
        mem_read_ready = 1'b1;
        mem_read_data  = 16'hF000;
        tick();
        if (mem_read_valid === 1'b1) pulses++;
        exp = {3'b010, 1'b0, 8'hFF, 16'hF000};
        total++;
        if (obs() !== exp) begin
            bad++;
            $display("FAIL zw_fetched got=%h want=%h", obs(), exp);
        end
        tick();
        if (mem_read_valid === 1'b1) pulses++;
        mem_read_ready = 1'b0;
        total++;
        if (fetcher_state !== 3'b010 || mem_read_valid !== 1'b0) begin
            bad++;
            $display("FAIL zw_refetch got=%h/%b want=2/0",
                     fetcher_state, mem_read_valid);
        end
        total++;
        if (pulses != 1) begin
            bad++;
            $display("FAIL zw_pulses got=%0d want=1", pulses);
        end
        go_idle();
    endtask

    task automatic test_stall();
        logic [27:0] exp;
        current_pc = 8'h40;
        core_state = C_FETCH;
        tick();
        enable = 1'b0;
        for (int i = 0; i < 4; i++) begin
            mem_read_ready = 1'b1;
            mem_read_data  = 16'hDEAD + 16'(i);
            current_pc     = 8'(8'h60 + i);
            tick();
            exp = {3'b001, 1'b1, 8'h40, 16'hF000};
            total++;
            if (obs() !== exp) begin
                bad++;
                $display("FAIL stall%0d got=%h want=%h", i, obs(), exp);
            end
        end
        core_state     = C_IDLE;
        enable         = 1'b1;
        mem_read_data  = 16'h7C11;
        tick();
        mem_read_ready = 1'b0;
        exp = {3'b010, 1'b0, 8'h40, 16'h7C11};
        total++;
        if (obs() !== exp) begin
            bad++;
            $display("FAIL stall_capture got=%h want=%h", obs(), exp);
        end
        enable     = 1'b0;
        core_state = C_DECODE;
        tick();
        total++;
        if (fetcher_state !== 3'b010) begin
            bad++;
            $display("FAIL stall_frozen got=%h want=2", fetcher_state);
        end
        enable = 1'b1;
        tick();
        core_state = C_IDLE;
        total++;
        if (fetcher_state !== 3'b000) begin
            bad++;
            $display("FAIL stall_release got=%h want=0", fetcher_state);
        end
    endtask

    task automatic test_spurious();
        logic [27:0] exp;
        mem_read_ready = 1'b1;
        mem_read_data  = 16'hBEEF;
        tick();
        tick();
        mem_read_ready = 1'b0;
        exp = {3'b000, 1'b0, 8'h40, 16'h7C11};
        total++;
        if (obs() !== exp) begin
            bad++;
            $display("FAIL spur_idle got=%h want=%h", obs(), exp);
        end
        do_fetch(8'h33, 16'h1111, 0);
        core_state     = C_EXEC;
        mem_read_ready = 1'b1;
        mem_read_data  = 16'hBEEF;
        tick();
        core_state = C_FETCH;
        tick();
        mem_read_ready = 1'b0;
        exp = {3'b010, 1'b0, 8'h33, 16'h1111};
        total++;
        if (obs() !== exp) begin
            bad++;
            $display("FAIL spur_fetched got=%h want=%h", obs(), exp);
        end
        go_idle();
    endtask

    task automatic test_hit();
        logic [27:0] exp;
        do_fetch(8'h20, 16'hA5A5, 1);
        go_idle();
        current_pc = 8'h20;
        core_state = C_FETCH;
        tick();
        core_state = C_IDLE;
`ifdef FETCH_PC_HIT_EN
        exp = {3'b010, 1'b0, 8'h20, 16'hA5A5};
        total++;
        if (obs() !== exp) begin
            bad++;
            $display("FAIL hit_same got=%h want=%h", obs(), exp);
        end
`else
        exp = {3'b001, 1'b1, 8'h20, 16'hA5A5};
        total++;
        if (obs() !== exp) begin
            bad++;
            $display("FAIL hit_same got=%h want=%h", obs(), exp);
        end
        mem_read_ready = 1'b1;
        mem_read_data  = 16'h0B0B;
        tick();
        mem_read_ready = 1'b0;
`endif
        go_idle();
        current_pc = 8'h21;
        core_state = C_FETCH;
        tick();
        core_state = C_IDLE;
        total++;
        if (mem_read_valid !== 1'b1 || mem_read_address !== 8'h21 ||
            fetcher_state !== 3'b001) begin
            bad++;
            $display("FAIL hit_miss got=%h want valid=1 addr=21 st=1", obs());
        end
        mem_read_ready = 1'b1;
        mem_read_data  = 16'h2121;
        tick();
        mem_read_ready = 1'b0;
        go_idle();
    endtask

    // Reference model: tracks the fetch transaction, not the RTL encoding.
    int          m_phase;
    bit          m_req;
    logic [7:0]  m_addr;
    logic [15:0] m_instr;
    bit          m_tag_ok;
    logic [7:0]  m_tag;

    task automatic model_edge();
        if (!enable) return;
        if (m_phase == 0) begin
            if (core_state == C_FETCH) begin
`ifdef FETCH_PC_HIT_EN
                if (m_tag_ok && m_tag == current_pc) begin
                    m_phase = 2;
                    return;
                end
`endif
                m_req   = 1;
                m_addr  = current_pc;
                m_phase = 1;
            end
        end else if (m_phase == 1) begin
            if (mem_read_ready) begin
                m_instr  = mem_read_data;
                m_req    = 0;
                m_phase  = 2;
                m_tag_ok = 1;
                m_tag    = m_addr;
            end
        end else if (core_state == C_DECODE) begin
            m_phase = 0;
        end
    endtask

    task automatic test_random();
        logic [27:0] exp;
        reset = 1'b1;
        #1 reset = 1'b0;
        m_phase  = 0;
        m_req    = 0;
        m_addr   = '0;
        m_instr  = '0;
        m_tag_ok = 0;
        m_tag    = '0;
        for (int i = 0; i < 400; i++) begin
            enable         = ($urandom_range(0, 99) < 85);
            core_state     = ($urandom_range(0, 1) == 0) ? C_FETCH
                           : 3'($urandom_range(0, 7));
            current_pc     = 8'(8'h20 + $urandom_range(0, 3));
            mem_read_ready = ($urandom_range(0, 1) == 1);
            mem_read_data  = 16'($urandom);
            model_edge();
            tick();
            exp = {3'(m_phase), m_req, m_addr, m_instr};
            total++;
            if (obs() !== exp) begin
                bad++;
                $display("FAIL rand%0d got=%h want=%h", i, obs(), exp);
            end
        end
        enable         = 1'b1;
        mem_read_ready = 1'b0;
        core_state     = C_IDLE;
    endtask

    initial begin
        reset          = 1'b1;
        enable         = 1'b1;
        core_state     = C_IDLE;
        current_pc     = 8'h00;
        mem_read_ready = 1'b0;
        mem_read_data  = 16'h0000;
        #1;
        test_reset();
        test_basic();
        test_zero_wait();
        test_stall();
        test_spurious();
        test_hit();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
